// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: state encoding, oversampling
// constants and the baud divider function (also intended for uart_tx).
package uart_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } rx_state_e;

    localparam int         OVERSAMPLE_FIXED = 16;

    // Oversample tick indices: three votes around mid-bit, then end of bit.
    localparam logic [3:0] TICK_SAMPLE0 = 4'd7;
    localparam logic [3:0] TICK_SAMPLE1 = 4'd8;
    localparam logic [3:0] TICK_VOTE    = 4'd9;
    localparam logic [3:0] TICK_LAST    = 4'd15;

    // Rounded clocks-per-oversample-tick.
    function automatic int uart_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rx_baud_tick.sv
// Oversample tick prescaler: counts 0..DIV-1, one-clk tick at DIV-1.
// A synchronous clear realigns the phase to a detected start edge.
module uart_rx_baud_tick #(
    parameter int DIV = 68
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: wrap at the terminal value or restart on clear.
    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST) && !clr_i;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote and a
// one-entry valid/ready output register.
//
// state   | meaning
// IDLE    | line idle, waiting for a low level on rx_s
// START   | start bit; a high vote means a glitch, return to IDLE
// DATA    | eight data bits, LSB first, shifted in at the vote tick
// STOP    | stop bit vote: deliver byte, flag overrun, or frame error
// BREAK   | stop bit was low; wait for the line to return high
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = 125_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV = uart_div(CLK_HZ, BAUD, OVERSAMPLE);

    if (DIV < 2) begin : g_div_chk
        $error("uart_rx: clock too slow for baud rate, divider below 2");
    end
    if (OVERSAMPLE != OVERSAMPLE_FIXED) begin : g_os_chk
        $error("uart_rx: only 16x oversampling is supported");
    end

    rx_state_e  state_q, state_d;
    logic       rx_meta_q, rx_s_q;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] samp_q, samp_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;
    logic       tick;
    logic       maj;
    logic       at_vote;
    logic       at_end;

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Prescaler held at zero while idle so bit timing starts at the edge.
    uart_rx_baud_tick #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == S_IDLE),
        .tick_o (tick)
    );

    // Majority of the two stored samples and the live sample at the vote tick.
    always_comb begin
        maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
        at_vote = tick && (tick_cnt_q == TICK_VOTE);
        at_end  = tick && (tick_cnt_q == TICK_LAST);
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        samp_d      = samp_q;
        data_d      = data_q;
        valid_d     = valid_q & ~ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (tick) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
            if (tick_cnt_q == TICK_SAMPLE0) samp_d[0] = rx_s_q;
            if (tick_cnt_q == TICK_SAMPLE1) samp_d[1] = rx_s_q;
        end

        case (state_q)
            S_IDLE: begin
                tick_cnt_d = 4'd0;
                bit_cnt_d  = 3'd0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (at_vote && maj) begin
                    state_d = S_IDLE;
                end else if (at_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (at_vote) shift_d = {maj, shift_q[7:1]};
                if (at_end) begin
                    if (bit_cnt_q == 3'd7) state_d = S_STOP;
                    else                   bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            S_STOP: begin
                // Resolve at mid stop bit so a following start edge is not missed.
                if (at_vote) begin
                    if (maj) begin
                        if (!valid_q || ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= 4'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            samp_q      <= 2'd0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            samp_q      <= samp_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: 1.6 MHz clock, 10 kbaud, 160 clks per bit.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int         total = 0;
    int         bad = 0;
    int         vld_cnt = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start bit, nbits data bits LSB first, then (if full frame) the stop bit.
    // A low stop bit leaves the line low.
    task automatic send_bits(input logic [7:0] b, input logic stop, input int nbits, input int bclk);
        rx = 1'b0;
        idle(bclk);
        for (int i = 0; i < nbits; i++) begin
            rx = b[i];
            idle(bclk);
        end
        if (nbits == 8) begin
            rx = stop;
            idle(bclk);
        end
    endtask

    // Monitor: sampled just after each rising edge.
    initial begin : monitor
        logic prev_valid;
        logic prev_ready;
        logic [7:0] e;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (prev_valid && prev_ready) begin
                total++;
                if (valid !== 1'b0) begin
                    bad++;
                    $display("FAIL valid_clear: got %0b expected 0", valid);
                end
            end
            if (valid && !prev_valid) begin
                vld_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none", data);
                end else begin
                    e = exp_q.pop_front();
                    if (data !== e) begin
                        bad++;
                        $display("FAIL rx_data: got 0x%0h expected 0x%0h", data, e);
                    end
                end
            end
            prev_valid = valid;
            prev_ready = ready;
        end
    end

    initial begin
        int fe0;
        int v0;
        idle(5);
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        idle(50);

        // Single byte.
        exp_q.push_back(8'hA5);
        send_bits(8'hA5, 1'b1, 8, 160);
        idle(320);
        check("a5_count", vld_cnt, 1);

        // Back-to-back frames.
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        send_bits(8'h00, 1'b1, 8, 160);
        send_bits(8'hFF, 1'b1, 8, 160);
        send_bits(8'h55, 1'b1, 8, 160);
        idle(320);
        check("b2b_count", vld_cnt, 4);
        check("b2b_ferr", fe_cnt, 0);
        check("b2b_ovr", ov_cnt, 0);

        // Short low glitch is rejected as a false start.
        v0 = vld_cnt;
        fe0 = fe_cnt;
        rx = 1'b0;
        idle(40);
        rx = 1'b1;
        idle(10);
        check("glitch_busy_hi", busy, 1);
        idle(200);
        check("glitch_busy_lo", busy, 0);
        check("glitch_no_valid", vld_cnt, v0);
        check("glitch_no_ferr", fe_cnt, fe0);

        // Framing error followed by a held-low line.
        send_bits(8'h3C, 1'b0, 8, 160);
        idle(500);
        check("brk_busy", busy, 1);
        check("brk_ferr", fe_cnt, 1);
        check("brk_valid", valid, 0);
        rx = 1'b1;
        idle(6);
        check("brk_release", busy, 0);
        idle(320);
        exp_q.push_back(8'h81);
        send_bits(8'h81, 1'b1, 8, 160);
        idle(320);
        check("after_brk_count", vld_cnt, 5);

        // Overrun while the consumer stalls.
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_bits(8'h11, 1'b1, 8, 160);
        send_bits(8'h22, 1'b1, 8, 160);
        idle(320);
        check("ovr_count", ov_cnt, 1);
        check("ovr_data", data, 8'h11);
        check("ovr_valid", valid, 1);
        ready = 1'b1;
        idle(2);
        check("ovr_drain", valid, 0);

        // Reset in the middle of a frame.
        send_bits(8'h77, 1'b1, 4, 160);
        idle(80);
        rst_n = 1'b0;
        idle(3);
        check("mid_rst_data", data, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_ovr", overrun, 0);
        rx = 1'b1;
        idle(5);
        rst_n = 1'b1;
        idle(320);
        exp_q.push_back(8'h9E);
        send_bits(8'h9E, 1'b1, 8, 160);
        idle(320);
        exp_q.push_back(8'h9E);
        send_bits(8'h9E, 1'b1, 8, 155);
        idle(320);
        exp_q.push_back(8'h9E);
        send_bits(8'h9E, 1'b1, 8, 165);
        idle(400);

        check("final_count", vld_cnt, 9);
        check("final_pending", exp_q.size(), 0);
        check("final_ferr", fe_cnt, 1);
        check("final_ovr", ov_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
